// File: rtl/mii_rx_pkg.sv
// rtl/mii_rx_pkg.sv - shared types, constants and CRC-32 helper for the MII/RMII receive framer
// Contents:
//   state_e      framer states
//   SFD, CRC_*   frame delimiter and CRC-32 constants
//   FCS_LEN      trailing FCS byte count held back by the delay line
//   crc32_byte   one reflected CRC-32 byte update
package mii_rx_pkg;

  typedef enum logic [1:0] {
    DROP     = 2'd0,
    IDLE     = 2'd1,
    PREAMBLE = 2'd2,
    DATA     = 2'd3
  } state_e;

  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam int          FCS_LEN     = 4;

  // Reflected CRC-32, LSB of the byte enters first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data_byte);
    logic [31:0] c;
    c = crc ^ {24'h000000, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_frame_if.sv
// rtl/mii_rx_frame_if.sv - PHY receive inputs and framed byte/status outputs of mii_rx_frame
// Signals:
//   rx_dv, rx_er, rx_data                 PHY receive side (rx_clk domain)
//   out_valid, out_data, out_sof          payload byte strobe (clk domain)
//   out_done, out_good, err_*, frame_len  end-of-frame strobe and status
//   busy                                  framer in PREAMBLE or DATA
// Modports: master = framer, slave = PHY driver / MAC consumer.
interface mii_rx_frame_if #(
  parameter int DATA_W = 4
);

  logic              rx_dv;
  logic              rx_er;
  logic [DATA_W-1:0] rx_data;

  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_sof;
  logic              out_done;
  logic              out_good;
  logic              err_crc;
  logic              err_len;
  logic              err_align;
  logic              err_phy;
  logic [15:0]       frame_len;
  logic              busy;

  modport master (
    input  rx_dv, rx_er, rx_data,
    output out_valid, out_data, out_sof, out_done, out_good,
           err_crc, err_len, err_align, err_phy, frame_len, busy
  );

  modport slave (
    output rx_dv, rx_er, rx_data,
    input  out_valid, out_data, out_sof, out_done, out_good,
           err_crc, err_len, err_align, err_phy, frame_len, busy
  );

endinterface

// File: rtl/mii_rx_edge_sync.sv
// rtl/mii_rx_edge_sync.sv - rx_clk synchroniser and rising-edge detector producing the symbol strobe
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rx_clk_i   PHY receive clock, sampled as data
//   sym_stb_o  one clk-cycle strobe per rx_clk rising edge
module mii_rx_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_clk_i,
  output logic sym_stb_o
);

  // [0],[1]: two-flop synchroniser; [2]: previous value for edge detect.
  logic [2:0] sync_q;
  logic       sym_stb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      sym_stb_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], rx_clk_i};
      sym_stb_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign sym_stb_o = sym_stb_q;

endmodule

// File: rtl/mii_rx_frame.sv
// rtl/mii_rx_frame.sv - MII/RMII receive framer: preamble/SFD detect, byte assembly, CRC-32, FCS strip, status
// Ports:
//   clk      system clock (at least 4x rx_clk)
//   reset_n  asynchronous active-low reset
//   rx_clk   PHY receive clock
//   bus      mii_rx_frame_if master: PHY inputs, payload byte stream and frame status
module mii_rx_frame
  import mii_rx_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int PRE_MAX = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           rx_clk,
  mii_rx_frame_if.master bus
);

  localparam int             SPB     = 8 / DATA_W;
  localparam int             PCW     = $clog2(PRE_MAX + 2);
  localparam logic [PCW-1:0] PRE_LIM = PCW'(PRE_MAX);
  localparam logic [15:0]    MIN16   = 16'(MIN_LEN);
  localparam logic [15:0]    MAX16   = 16'(MAX_LEN);
  localparam logic [15:0]    FCS16   = 16'(FCS_LEN);
  localparam logic [2:0]     FCS3    = 3'(FCS_LEN);
  localparam logic [3:0]     SYM_LST = 4'(SPB - 1);

  // PHY capture in the rx_clk domain. Deliberately not reset: a reset taken
  // while rx_dv is high must keep reading rx_dv=1 so DROP rejects the rest
  // of the frame instead of seeing a fake idle from a cleared flop.
  logic              rx_dv_q;
  logic              rx_er_q;
  logic [DATA_W-1:0] rx_data_q;

  always_ff @(posedge rx_clk) begin
    rx_dv_q   <= bus.rx_dv;
    rx_er_q   <= bus.rx_er;
    rx_data_q <= bus.rx_data;
  end

  logic sym_stb;

  mii_rx_edge_sync u_edge_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_clk_i  (rx_clk),
    .sym_stb_o (sym_stb)
  );

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [3:0]        sym_cnt_q, sym_cnt_d;
  logic [PCW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0][7:0]   dl_q, dl_d;         // [0] newest, [3] oldest
  logic [2:0]        fill_q, fill_d;
  logic              sof_pend_q, sof_pend_d;
  logic              phy_q, phy_d;

  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_sof_q, out_sof_d;
  logic              out_done_q, out_done_d;
  logic              out_good_q, out_good_d;
  logic              err_crc_q, err_crc_d;
  logic              err_len_q, err_len_d;
  logic              err_align_q, err_align_d;
  logic              err_phy_q, err_phy_d;
  logic [15:0]       frame_len_q, frame_len_d;

  logic [7:0]        sr_shift;
  logic [7:0]        sr_first;
  logic [PCW-1:0]    pre_cnt_inc;
  logic [15:0]       byte_cnt_inc;
  logic              e_crc, e_len, e_align, e_phy;

  // Symbols arrive LSB first, so each one enters at the top of the byte.
  assign sr_shift     = 8'({rx_data_q, sr_q} >> DATA_W);
  assign sr_first     = 8'({rx_data_q, 8'h00} >> DATA_W);
  assign pre_cnt_inc  = pre_cnt_q + PCW'(1);
  assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

  assign e_crc   = (crc_q != CRC_RESIDUE);
  assign e_len   = (byte_cnt_q < MIN16) || (byte_cnt_q > MAX16);
  assign e_align = (sym_cnt_q != 4'd0);
  assign e_phy   = phy_q | rx_er_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    sym_cnt_d   = sym_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    crc_d       = crc_q;
    byte_cnt_d  = byte_cnt_q;
    dl_d        = dl_q;
    fill_d      = fill_q;
    sof_pend_d  = sof_pend_q;
    phy_d       = phy_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sof_d   = 1'b0;
    out_done_d  = 1'b0;
    out_good_d  = out_good_q;
    err_crc_d   = err_crc_q;
    err_len_d   = err_len_q;
    err_align_d = err_align_q;
    err_phy_d   = err_phy_q;
    frame_len_d = frame_len_q;

    if (sym_stb) begin
      case (state_q)
        DROP: begin
          if (!rx_dv_q) state_d = IDLE;
        end

        IDLE: begin
          if (rx_dv_q) begin
            state_d   = PREAMBLE;
            sr_d      = sr_first;
            pre_cnt_d = PCW'(1);
          end
        end

        PREAMBLE: begin
          sr_d      = sr_shift;
          pre_cnt_d = pre_cnt_inc;
          if (!rx_dv_q) begin
            state_d = IDLE;
          end else if (sr_shift == SFD) begin
            state_d    = DATA;
            sym_cnt_d  = 4'd0;
            crc_d      = CRC_INIT;
            byte_cnt_d = 16'd0;
            fill_d     = 3'd0;
            sof_pend_d = 1'b1;
            phy_d      = 1'b0;
          end else if (pre_cnt_inc > PRE_LIM) begin
            state_d = DROP;
          end
        end

        DATA: begin
          if (!rx_dv_q) begin
            // The delay-line contents are the FCS and are simply abandoned.
            state_d     = IDLE;
            out_done_d  = 1'b1;
            err_crc_d   = e_crc;
            err_len_d   = e_len;
            err_align_d = e_align;
            err_phy_d   = e_phy;
            out_good_d  = !(e_crc || e_len || e_align || e_phy);
            frame_len_d = (byte_cnt_q >= FCS16) ? (byte_cnt_q - FCS16) : 16'd0;
          end else begin
            sr_d = sr_shift;
            if (rx_er_q) phy_d = 1'b1;
            if (sym_cnt_q == SYM_LST) begin
              sym_cnt_d  = 4'd0;
              crc_d      = crc32_byte(crc_q, sr_shift);
              byte_cnt_d = byte_cnt_inc;
              dl_d       = {dl_q[2:0], sr_shift};
              if (fill_q == FCS3) begin
                // Oldest byte is now known not to be FCS; stop emitting once over-length.
                if (byte_cnt_inc <= MAX16) begin
                  out_valid_d = 1'b1;
                  out_data_d  = dl_q[3];
                  out_sof_d   = sof_pend_q;
                  sof_pend_d  = 1'b0;
                end
              end else begin
                fill_d = fill_q + 3'd1;
              end
            end else begin
              sym_cnt_d = sym_cnt_q + 4'd1;
            end
          end
        end

        default: state_d = DROP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= DROP;
      sr_q        <= '0;
      sym_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      crc_q       <= CRC_INIT;
      byte_cnt_q  <= '0;
      dl_q        <= '0;
      fill_q      <= '0;
      sof_pend_q  <= 1'b0;
      phy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_done_q  <= 1'b0;
      out_good_q  <= 1'b0;
      err_crc_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_align_q <= 1'b0;
      err_phy_q   <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sym_cnt_q   <= sym_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      crc_q       <= crc_d;
      byte_cnt_q  <= byte_cnt_d;
      dl_q        <= dl_d;
      fill_q      <= fill_d;
      sof_pend_q  <= sof_pend_d;
      phy_q       <= phy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_done_q  <= out_done_d;
      out_good_q  <= out_good_d;
      err_crc_q   <= err_crc_d;
      err_len_q   <= err_len_d;
      err_align_q <= err_align_d;
      err_phy_q   <= err_phy_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_done  = out_done_q;
  assign bus.out_good  = out_good_q;
  assign bus.err_crc   = err_crc_q;
  assign bus.err_len   = err_len_q;
  assign bus.err_align = err_align_q;
  assign bus.err_phy   = err_phy_q;
  assign bus.frame_len = frame_len_q;
  assign bus.busy      = (state_q == PREAMBLE) || (state_q == DATA);

endmodule

// File: tb/tb_mii_rx_frame.sv
// tb/tb_mii_rx_frame.sv - scoreboard bench for mii_rx_frame, MII and RMII instances side by side
module tb_mii_rx_frame;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int PRE_MAX = 32;

  logic clk     = 1'b0;
  logic rx_clk  = 1'b0;
  logic reset_n = 1'b0;

  always #5  clk    = ~clk;
  always #40 rx_clk = ~rx_clk;

  mii_rx_frame_if #(.DATA_W(4)) bus4 ();
  mii_rx_frame_if #(.DATA_W(2)) bus2 ();

  mii_rx_frame #(.DATA_W(4), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .PRE_MAX(PRE_MAX)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_clk  (rx_clk),
    .bus     (bus4)
  );

  mii_rx_frame #(.DATA_W(2), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .PRE_MAX(PRE_MAX)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_clk  (rx_clk),
    .bus     (bus2)
  );

  int tests  = 0;
  int errors = 0;

  // {sof, byte} and {good, crc, len, align, phy, frame_len}; index 0 = MII, 1 = RMII
  logic [8:0]  eb0[$];
  logic [8:0]  eb1[$];
  logic [20:0] es0[$];
  logic [20:0] es1[$];

  function automatic logic [31:0] fcs_of(input logic [7:0] d[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(output logic [7:0] f[$], input int plen, input bit incr);
    logic [31:0] c;
    f = {};
    for (int i = 0; i < plen; i++) f.push_back(incr ? 8'(i) : 8'($urandom));
    c = fcs_of(f, plen);
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
  endtask

  // Expected behaviour: every byte except the trailing four, truncated at MAX_LEN total,
  // and a status derived from whether the trailing four bytes are the FCS of the rest.
  task automatic expect_frame(input int d, input logic [7:0] f[$], input bit align, input bit phy);
    int n, lim, emit;
    bit crc_bad, len_bad, good;
    logic [15:0] flen;
    logic [31:0] c;
    n    = f.size();
    lim  = (n > MAX_LEN) ? MAX_LEN : n;
    emit = lim - 4;
    for (int i = 0; i < emit; i++) begin
      if (d == 0) eb0.push_back({i == 0, f[i]});
      else        eb1.push_back({i == 0, f[i]});
    end
    crc_bad = 1'b1;
    if (n >= 4) begin
      c = fcs_of(f, n - 4);
      crc_bad = (c != {f[n-1], f[n-2], f[n-3], f[n-4]});
    end
    len_bad = (n < MIN_LEN) || (n > MAX_LEN);
    flen    = (n >= 4) ? 16'(n - 4) : 16'd0;
    good    = !(crc_bad || len_bad || align || phy);
    if (d == 0) es0.push_back({good, crc_bad, len_bad, align, phy, flen});
    else        es1.push_back({good, crc_bad, len_bad, align, phy, flen});
  endtask

  task automatic drive(input int d, input logic dv, input logic er, input logic [3:0] sym);
    @(negedge rx_clk);
    if (d == 0) begin
      bus4.rx_dv = dv; bus4.rx_er = er; bus4.rx_data = sym;
    end else begin
      bus2.rx_dv = dv; bus2.rx_er = er; bus2.rx_data = sym[1:0];
    end
  endtask

  task automatic send(input int d, input int pre_n, input logic [7:0] f[$], input int extra,
                      input int er_byte, input int abort_byte);
    logic [7:0] b[$];
    logic [3:0] sym;
    int w, spb, di;
    w   = (d == 0) ? 4 : 2;
    spb = 8 / w;
    b   = {};
    repeat (pre_n) b.push_back(8'h55);
    b.push_back(8'hD5);
    foreach (f[i]) b.push_back(f[i]);
    for (int i = 0; i < b.size(); i++) begin
      di = i - pre_n - 1;
      for (int s = 0; s < spb; s++) begin
        sym = 4'(b[i] >> (s * w));
        if (abort_byte >= 0 && di == abort_byte && s == 0) begin
          @(negedge clk);
          reset_n = 1'b0;
          repeat (3) @(negedge clk);
          reset_n = 1'b1;
        end
        drive(d, 1'b1, (er_byte >= 0 && di == er_byte && s == 0), sym);
      end
    end
    repeat (extra) drive(d, 1'b1, 1'b0, 4'($urandom));
    repeat (6) drive(d, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic check_byte(input int d, input logic [8:0] act);
    logic [8:0] e;
    int sz;
    sz = (d == 0) ? eb0.size() : eb1.size();
    tests++;
    if (sz == 0) begin
      errors++;
      $display("FAIL byte dut%0d: got unexpected sof=%0d data=%02h, required no byte", d, act[8], act[7:0]);
    end else begin
      if (d == 0) e = eb0.pop_front();
      else        e = eb1.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL byte dut%0d: got sof=%0d data=%02h, required sof=%0d data=%02h",
                 d, act[8], act[7:0], e[8], e[7:0]);
      end
    end
  endtask

  task automatic check_st(input int d, input logic [20:0] act);
    logic [20:0] e;
    int pend, sz;
    pend = (d == 0) ? eb0.size() : eb1.size();
    tests++;
    if (pend != 0) begin
      errors++;
      $display("FAIL bytes_before_done dut%0d: got %0d bytes missing, required 0", d, pend);
      if (d == 0) eb0.delete(); else eb1.delete();
    end
    sz = (d == 0) ? es0.size() : es1.size();
    tests++;
    if (sz == 0) begin
      errors++;
      $display("FAIL status dut%0d: got unexpected out_done, required none", d);
    end else begin
      if (d == 0) e = es0.pop_front();
      else        e = es1.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL status dut%0d: got good=%0d crc=%0d len=%0d align=%0d phy=%0d flen=%0d, required good=%0d crc=%0d len=%0d align=%0d phy=%0d flen=%0d",
                 d, act[20], act[19], act[18], act[17], act[16], act[15:0],
                 e[20], e[19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus4.out_valid && bus4.out_done) begin
      tests++; errors++;
      $display("FAIL exclusive dut0: got valid=1 done=1, required not both");
    end
    if (bus4.out_valid) check_byte(0, {bus4.out_sof, bus4.out_data});
    if (bus4.out_done)
      check_st(0, {bus4.out_good, bus4.err_crc, bus4.err_len, bus4.err_align, bus4.err_phy, bus4.frame_len});
  end

  always @(negedge clk) begin
    if (bus2.out_valid && bus2.out_done) begin
      tests++; errors++;
      $display("FAIL exclusive dut1: got valid=1 done=1, required not both");
    end
    if (bus2.out_valid) check_byte(1, {bus2.out_sof, bus2.out_data});
    if (bus2.out_done)
      check_st(1, {bus2.out_good, bus2.err_crc, bus2.err_len, bus2.err_align, bus2.err_phy, bus2.frame_len});
  end

  task automatic check_empty(input string name, input int sz);
    tests++;
    if (sz != 0) begin
      errors++;
      $display("FAIL %s: got %0d entries never produced, required 0", name, sz);
    end
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] s[$];
    logic [32:0] rv;
    int d, plen, idx;

    bus4.rx_dv = 1'b0; bus4.rx_er = 1'b0; bus4.rx_data = '0;
    bus2.rx_dv = 1'b0; bus2.rx_er = 1'b0; bus2.rx_data = '0;
    reset_n = 1'b0;
    repeat (20) @(negedge clk);

    rv = {bus4.out_valid, bus4.out_data, bus4.out_sof, bus4.out_done, bus4.out_good, bus4.err_crc,
          bus4.err_len, bus4.err_align, bus4.err_phy, bus4.frame_len, bus4.busy};
    tests++;
    if (rv !== 33'd0) begin errors++; $display("FAIL reset dut0: got %09h, required 0", rv); end
    rv = {bus2.out_valid, bus2.out_data, bus2.out_sof, bus2.out_done, bus2.out_good, bus2.err_crc,
          bus2.err_len, bus2.err_align, bus2.err_phy, bus2.frame_len, bus2.busy};
    tests++;
    if (rv !== 33'd0) begin errors++; $display("FAIL reset dut1: got %09h, required 0", rv); end

    reset_n = 1'b1;
    repeat (4) @(negedge rx_clk);

    // Good 64-byte frame, MII then RMII
    build(f, 60, 1'b1);
    expect_frame(0, f, 1'b0, 1'b0); send(0, 7, f, 0, -1, -1);
    expect_frame(1, f, 1'b0, 1'b0); send(1, 7, f, 0, -1, -1);

    // Payload byte 10 corrupted after FCS computed
    build(f, 60, 1'b1);
    f[10] = 8'hFF;
    expect_frame(0, f, 1'b0, 1'b0); send(0, 7, f, 0, -1, -1);

    // One trailing partial symbol
    build(f, 60, 1'b1);
    expect_frame(0, f, 1'b1, 1'b0); send(0, 7, f, 1, -1, -1);
    expect_frame(1, f, 1'b1, 1'b0); send(1, 7, f, 1, -1, -1);

    // rx_er pulse mid-payload
    build(f, 60, 1'b0);
    expect_frame(0, f, 1'b0, 1'b1); send(0, 7, f, 0, 20, -1);

    // Two-byte runt
    s = {};
    s.push_back(8'($urandom)); s.push_back(8'($urandom));
    expect_frame(0, s, 1'b0, 1'b0); send(0, 7, s, 0, -1, -1);

    // Preamble of exactly PRE_MAX symbols accepted; one byte more is dropped silently
    build(f, 60, 1'b0);
    expect_frame(0, f, 1'b0, 1'b0); send(0, 15, f, 0, -1, -1);
    build(f, 60, 1'b0);
    send(0, 16, f, 0, -1, -1);

    // Reset mid-payload with rx_dv held, then a good frame
    build(f, 60, 1'b0);
    send(0, 7, f, 0, -1, 2);
    build(f, 60, 1'b0);
    expect_frame(0, f, 1'b0, 1'b0); send(0, 7, f, 0, -1, -1);

    // Randomised frames
    for (int r = 0; r < 6; r++) begin
      d    = int'($urandom_range(0, 1));
      plen = int'($urandom_range(40, (d == 0) ? 120 : 70));
      build(f, plen, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, plen - 1));
        f[idx] = f[idx] ^ 8'h5A;
      end
      expect_frame(d, f, 1'b0, 1'b0);
      send(d, int'($urandom_range(1, 7)), f, 0, -1, -1);
    end

    // 1519-byte frame with valid FCS
    build(f, 1515, 1'b0);
    expect_frame(0, f, 1'b0, 1'b0); send(0, 7, f, 0, -1, -1);

    repeat (100) @(negedge clk);
    check_empty("pending_bytes_dut0", eb0.size());
    check_empty("pending_bytes_dut1", eb1.size());
    check_empty("pending_status_dut0", es0.size());
    check_empty("pending_status_dut1", es1.size());

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
